fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader_pkg.sv | 10 +
 rtl/fifo_burst_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_burst_reader.sv
// Reads a requested number of beats from an upstream FIFO and streams them out.
// Optional source-empty timeout enabled by FIFO_BURST_READER_TIMEOUT_EN.
//
//   state    | meaning
//   ST_IDLE  | ready for a burst request
//   ST_BURST | popping beats from the upstream FIFO
//   ST_DRAIN | all beats popped, waiting for the last beat to be accepted
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DW      = 16,
   parameter int LW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [DW-1:0] src_data,
   input  logic          src_valid,
   output logic          src_pop,
   input  logic          req_valid,
   input  logic [LW-1:0] req_len,
   output logic          req_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          out_last,
   input  logic          out_ready,
   output logic          done,
   output logic          abort
);

   state_t        state, state_nxt;
   logic [LW-1:0] remaining;
   logic          done_nxt;
   logic          abort_nxt;
   logic          beat_acc;
   logic          tmo_hit;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Counts consecutive empty-source cycles; any pop or leaving BURST restarts it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         tmo_cnt <= '0;
      end else if (state != ST_BURST || src_pop || tmo_hit) begin
         tmo_cnt <= '0;
      end else if (!src_valid) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_hit = (state == ST_BURST) && !src_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   // TIMEOUT only matters when the timeout build option is on.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit        = 1'b0;
`endif

   assign req_ready = (state == ST_IDLE);
   assign beat_acc  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      src_pop   = (state == ST_BURST) && src_valid && (remaining != '0)
                  && (!out_valid || out_ready) && !flush;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_len != '0) state_nxt = ST_BURST;
               else               done_nxt  = 1'b1;
            end
         end
         ST_BURST: begin
            if (src_pop && remaining == LW'(1)) begin
               state_nxt = ST_DRAIN;
            end else if (tmo_hit) begin
               state_nxt = ST_IDLE;
               abort_nxt = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (beat_acc && out_last) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt = ST_IDLE;
         done_nxt  = 1'b0;
         abort_nxt = 1'b0;
      end
   end

   // A beat held at timeout stays valid until accepted, even back in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         remaining <= '0;
         done      <= 1'b0;
         abort     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         remaining <= '0;
         done      <= 1'b0;
         abort     <= 1'b0;
      end else begin
         done  <= done_nxt;
         abort <= abort_nxt;
         if (state == ST_IDLE && req_valid) begin
            remaining <= req_len;
         end
         if (src_pop) begin
            out_data  <= src_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == LW'(1));
            remaining <= remaining - LW'(1);
         end else if (beat_acc) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (tmo_hit) begin
            remaining <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: upstream FIFO model, expected-beat queue.
module tb_fifo_burst_reader;

   localparam int DW = 16;
   localparam int LW = 4;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic [DW-1:0] src_data;
   logic          src_valid, src_pop;
   logic          req_valid, req_ready;
   logic [LW-1:0] req_len;
   logic [DW-1:0] out_data;
   logic          out_valid, out_last, out_ready;
   logic          done, abort;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [0:15];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   beat_t         exp_q [$];

   int    pops = 0, dones = 0, aborts = 0, cyc = 0;
   int    first_pop_cyc = 0, last_pop_cyc = 0;
   logic  prev_cause = 1'b0;
   logic  held_v = 1'b0;
   beat_t held_b;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DW(DW), .LW(LW), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .src_data(src_data), .src_valid(src_valid), .src_pop(src_pop),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .done(done), .abort(abort)
   );

   assign src_valid = (wr_ptr != rd_ptr);
   assign src_data  = mem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (src_pop) rd_ptr <= rd_ptr + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      cyc++;
      if (!rst) begin
         if (held_v) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(held_b.d));
            chk("hold_last", 32'(out_last), 32'(held_b.l));
         end
         if (src_pop) begin
            if (pops == 0) first_pop_cyc = cyc;
            pops++;
            last_pop_cyc = cyc;
         end
         if (done) begin
            dones++;
            chk("done_cause", 32'(prev_cause), 1);
         end
         if (abort) aborts++;
         if (out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 32'(out_data), 32'(e.d));
               chk("beat_last", 32'(out_last), 32'(e.l));
            end
         end
      end
      held_v     = out_valid && !out_ready && !flush && !rst;
      held_b     = '{d: out_data, l: out_last};
      prev_cause = !flush && !rst &&
                   ((out_valid && out_ready && out_last) ||
                    (req_valid && req_ready && req_len == '0));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic l);
      mem[wr_ptr[3:0]] = d;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back('{d: d, l: l});
   endtask

   task automatic issue(input logic [LW-1:0] len);
      req_valid = 1'b1;
      req_len   = len;
      step();
      req_valid = 1'b0;
      req_len   = '0;
   endtask

   task automatic wait_dones(input string tag, input int target, input int budget);
      int n = 0;
      while (dones < target && n < budget) begin
         step();
         n++;
      end
      if (dones < target) chk(tag, 32'(dones), 32'(target));
   endtask

   task automatic wait_pops(input string tag, input int target, input int budget);
      int n = 0;
      while (pops < target && n < budget) begin
         step();
         n++;
      end
      if (pops < target) chk(tag, 32'(pops), 32'(target));
   endtask

   initial begin
      int p0, d0, n;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_len = '0; out_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_abort", 32'(abort), 0);
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_src_pop", 32'(src_pop), 0);

      // three-beat burst at full throughput
      push_beat(16'h00A1, 1'b0); push_beat(16'h00B2, 1'b0); push_beat(16'h00C3, 1'b1);
      pops = 0;
      issue(4'd3);
      chk("b3_req_ready_low", 32'(req_ready), 0);
      wait_dones("b3_done_timeout", 1, 20);
      chk("b3_pops", 32'(pops), 3);
      chk("b3_pop_span", 32'(last_pop_cyc - first_pop_cyc), 2);
      repeat (3) step();
      chk("b3_done_once", 32'(dones), 1);
      chk("b3_sb_empty", 32'(exp_q.size()), 0);

      // backpressure holds the first beat
      out_ready = 1'b0;
      push_beat(16'h1111, 1'b0); push_beat(16'h2222, 1'b1);
      pops = 0;
      issue(4'd2);
      n = 0;
      while (!out_valid && n < 10) begin step(); n++; end
      chk("bp_first_valid", 32'(out_valid), 1);
      repeat (4) step();
      chk("bp_one_pop", 32'(pops), 1);
      chk("bp_held_data", 32'(out_data), 32'h1111);
      out_ready = 1'b1;
      wait_dones("bp_done_timeout", 2, 20);
      chk("bp_pops", 32'(pops), 2);
      chk("bp_sb_empty", 32'(exp_q.size()), 0);

      // source runs dry after two beats, then flush
      push_beat(16'h3333, 1'b0); push_beat(16'h4444, 1'b0);
      pops = 0;
      d0 = dones;
      issue(4'd4);
      wait_pops("fl_pop_timeout", 2, 20);
      repeat (4) step();
      chk("fl_stall_busy", 32'(req_ready), 0);
      chk("fl_stall_pops", 32'(pops), 2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_req_ready", 32'(req_ready), 1);
      chk("fl_out_valid", 32'(out_valid), 0);
      chk("fl_done", 32'(done), 0);
      repeat (2) step();
      chk("fl_no_done", 32'(dones), d0);

      // zero-length request
      pops = 0;
      d0 = dones;
      issue(4'd0);
      chk("z_done", 32'(done), 1);
      chk("z_out_valid", 32'(out_valid), 0);
      step();
      chk("z_done_pulse", 32'(done), 0);
      chk("z_no_pop", 32'(pops), 0);
      chk("z_done_count", 32'(dones), d0 + 1);

      // empty source while in BURST
      issue(4'd2);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      n = 0;
      while (!abort && n < 40) begin step(); n++; end
      chk("to_cycles", 32'(n), 15);
      chk("to_abort", 32'(abort), 1);
      chk("to_idle", 32'(req_ready), 1);
      step();
      chk("to_abort_pulse", 32'(abort), 0);
      chk("to_abort_count", 32'(aborts), 1);
`else
      repeat (100) step();
      chk("nt_still_busy", 32'(req_ready), 0);
      chk("nt_no_abort", 32'(aborts), 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("nt_flush_idle", 32'(req_ready), 1);
`endif

      // reset in the middle of a four-beat burst
      push_beat(16'h5555, 1'b0); push_beat(16'h6666, 1'b0);
      push_beat(16'h7777, 1'b0); push_beat(16'h8888, 1'b1);
      pops = 0;
      d0 = dones;
      p0 = aborts;
      issue(4'd4);
      wait_pops("rs_pop_timeout", 2, 20);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wr_ptr = rd_ptr;
      exp_q.delete();
      chk("rs_out_valid", 32'(out_valid), 0);
      chk("rs_out_last", 32'(out_last), 0);
      chk("rs_done", 32'(done), 0);
      chk("rs_abort", 32'(abort), 0);
      chk("rs_req_ready", 32'(req_ready), 1);
      repeat (3) step();
      chk("rs_no_done", 32'(dones), d0);
      chk("rs_no_abort", 32'(aborts), p0);
      chk("rs_no_beats", 32'(out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
